// File: rtl/mul_out_stage.sv
// Output stage for the FP multiplier: buffers results with their IEEE flags,
// accumulates sticky flags and counts delivered results.
module mul_out_stage #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  in_a,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  in_b,
    input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  in_res,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0]  out_res,
    output logic [3:0]                       out_flags,
    output logic [3:0]                       fflags,
    input  logic                             flag_clr,
    output logic [15:0]                      op_cnt
);

    localparam int W  = SIGN_W + EXPO_W + MANT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  res_mem [DEPTH];
    logic [3:0]    flg_mem [DEPTH];
    logic          empty, full, push, pop;

    // Field decode of operands and result
    logic [EXPO_W-1:0] a_exp, b_exp, r_exp;
    logic [MANT_W-1:0] a_man, b_man, r_man;
    logic a_ones, b_ones, r_ones, a_zexp, b_zexp;
    logic a_inf, b_inf, a_snan, b_snan;
    logic [3:0] new_flags;
    logic unused_signs;

    assign a_exp = in_a[MANT_W +: EXPO_W];
    assign b_exp = in_b[MANT_W +: EXPO_W];
    assign r_exp = in_res[MANT_W +: EXPO_W];
    assign a_man = in_a[MANT_W-1:0];
    assign b_man = in_b[MANT_W-1:0];
    assign r_man = in_res[MANT_W-1:0];
    assign unused_signs = ^{in_a[W-1 -: SIGN_W], in_b[W-1 -: SIGN_W]};

    assign a_ones = &a_exp;
    assign b_ones = &b_exp;
    assign r_ones = &r_exp;
    assign a_zexp = (a_exp == '0);
    assign b_zexp = (b_exp == '0);
    assign a_inf  = a_ones && (a_man == '0);
    assign b_inf  = b_ones && (b_man == '0);
    assign a_snan = a_ones && (a_man != '0) && !a_man[MANT_W-1];
    assign b_snan = b_ones && (b_man != '0) && !b_man[MANT_W-1];

    // {NV, INF, ZR, QN}
    always_comb begin
        new_flags    = '0;
        new_flags[3] = (a_zexp && b_inf) || (b_zexp && a_inf) || a_snan || b_snan;
        new_flags[2] = !a_ones && !b_ones && r_ones && (r_man == '0);
        new_flags[1] = !a_zexp && !a_ones && !b_zexp && !b_ones
                       && (r_exp == '0) && (r_man == '0);
        new_flags[0] = r_ones && (r_man != '0);
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_res   = res_mem[rd_ptr[AW-1:0]];
    assign out_flags = flg_mem[rd_ptr[AW-1:0]];

    // Entry storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr[AW-1:0]] <= in_res;
            flg_mem[wr_ptr[AW-1:0]] <= new_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fflags <= '0;
            op_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                op_cnt <= op_cnt + 16'd1;
                // The popped flags win over a simultaneous clear.
                if (flag_clr)
                    fflags <= out_flags;
                else
                    fflags <= fflags | out_flags;
            end else if (flag_clr) begin
                fflags <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mul_out_stage.sv
// Directed bench for mul_out_stage with hand-computed expectations.
module tb_mul_out_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b, in_res;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic [3:0]  out_flags, fflags;
    logic        flag_clr;
    logic [15:0] op_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mul_out_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags),
        .fflags    (fflags),
        .flag_clr  (flag_clr),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_res   = r;
    endtask

    initial begin
        rst = 1'b1;
        flag_clr = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_op_cnt",    {16'b0, op_cnt},    32'd0);
        check("rst_fflags",    {28'b0, fflags},    32'd0);
        rst = 1'b0;

        // single op, out_ready already high
        out_ready = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h40000000, 32'h40000000);
        check("single_no_bypass", {31'b0, out_valid}, 32'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_res",   out_res,            32'h40000000);
        check("single_flags", {28'b0, out_flags}, 32'h0);
        step();
        check("single_cnt",   {16'b0, op_cnt},    32'd1);
        check("single_empty", {31'b0, out_valid}, 32'd0);
        check("single_ff",    {28'b0, fflags},    32'h0);

        // invalid op 0 * inf
        out_ready = 1'b0;
        drive(1'b1, 32'h00000000, 32'h7F800000, 32'hFFC00000);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("nv_flags", {28'b0, out_flags}, 32'b1001);
        out_ready = 1'b1;
        step();
        check("nv_ff",  {28'b0, fflags}, 32'b1001);
        check("nv_cnt", {16'b0, op_cnt}, 32'd2);
        out_ready = 1'b0;
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("clr_nopop", {28'b0, fflags}, 32'b0000);

        // backpressure with 3 offers
        drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h11111111);
        step();
        check("bp_ready1", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h22222222);
        step();
        check("bp_ready2", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h33333333);
        step();
        check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        check("bp_head1", out_res, 32'h11111111);
        out_ready = 1'b1;
        step();
        check("bp_head2", out_res, 32'h22222222);
        check("bp_ready3", {31'b0, in_ready}, 32'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("bp_head3",  out_res,            32'h33333333);
        check("bp_valid3", {31'b0, out_valid}, 32'd1);
        step();
        check("bp_empty", {31'b0, out_valid}, 32'd0);
        check("bp_cnt",   {16'b0, op_cnt},    32'd5);

        // overflow then underflow, popped back-to-back
        out_ready = 1'b0;
        drive(1'b1, 32'h7F000000, 32'h7F000000, 32'h7F800000);
        step();
        check("inf_flags", {28'b0, out_flags}, 32'b0100);
        drive(1'b1, 32'h00800000, 32'h00800000, 32'h00000000);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        check("ovf_ff",   {28'b0, fflags},    32'b0100);
        check("zr_flags", {28'b0, out_flags}, 32'b0010);
        step();
        check("ovf_unf_ff", {28'b0, fflags}, 32'b0110);
        check("ovf_cnt",    {16'b0, op_cnt}, 32'd7);

        // clear coinciding with a pop of an INF entry
        out_ready = 1'b0;
        drive(1'b1, 32'h7F000000, 32'h7F000000, 32'h7F800000);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        out_ready = 1'b1;
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("clr_pop_ff", {28'b0, fflags}, 32'b0100);

        // signalling NaN operand
        out_ready = 1'b0;
        drive(1'b1, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("snan_flags", {28'b0, out_flags}, 32'b1001);
        out_ready = 1'b1;
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("snan_ff",  {28'b0, fflags}, 32'b1001);
        check("snan_cnt", {16'b0, op_cnt}, 32'd9);

        // async reset with two entries held
        out_ready = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 32'hAAAA0000);
        step();
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        check("full_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_ready", {31'b0, in_ready},  32'd1);
        check("arst_cnt",   {16'b0, op_cnt},    32'd0);
        check("arst_ff",    {28'b0, fflags},    32'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h12345678);
        step();
        check("post_rst_push", {31'b0, out_valid}, 32'd1);
        check("post_rst_res",  out_res,            32'h12345678);

        // one entry held: each edge now pushes and pops, 65537 pops total
        out_ready = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        check("cnt_wrap",       {16'b0, op_cnt},    32'd1);
        check("cnt_wrap_valid", {31'b0, out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
